multicycle_core: RTL

Parametrised multicycle RISC-V integer core. It combines the datapath (PC, IR, regfile, A/B/ALUOut/MDR registers, immediate generator, ALU) with its own control FSM. Instruction and data traffic use one shared external memory port with a req/ready handshake, so memory wait states are supported. It is the next generation of the datapath-only processing block: XLEN is configurable, and control and immediates are internal.

---
 rtl/multicycle_core.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_core.sv
// multicycle_core: multicycle RV integer core (ADD/SUB/AND/OR/ADDI/LUI/BEQ/BNE,
// LD/SD or LW/SW, ECALL) with one shared req/ready memory port.
// Ports:
//   clk, reset (async, active-low)
//   mem_req/mem_we/mem_addr/mem_wdata -> shared memory request
//   mem_rdata/mem_ready               <- memory response (fetch uses [31:0])
//   instruction_out, pc_out           -> current IR and PC
//   halted, illegal                   -> sticky stop flags (ECALL / bad encoding)
//   dbg_rs -> dbg_rdata               -> combinational register peek, x0 = 0
module multicycle_core #(
  parameter int unsigned     XLEN     = 64,
  parameter int unsigned     ADDR_W   = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              mem_ready,
  output logic [31:0]       instruction_out,
  output logic [XLEN-1:0]   pc_out,
  output logic              halted,
  output logic              illegal,
  input  logic [4:0]        dbg_rs,
  output logic [XLEN-1:0]   dbg_rdata
);

  localparam int unsigned NREGS  = 32;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BR     = 7'b1100011;
  localparam logic [6:0] OP_LD     = 7'b0000011;
  localparam logic [6:0] OP_ST     = 7'b0100011;
  localparam logic [2:0] F3_LS     = (XLEN == 64) ? 3'b011 : 3'b010;
  localparam logic [31:0] ECALL_IR = 32'h0000_0073;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_TRAP
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [XLEN-1:0] r_pc, r_pc_old, r_a, r_b, r_aluout, r_mdr;
  logic [31:0]     r_ir;
  logic            r_halted, r_illegal;
  logic [XLEN-1:0] r_regs [NREGS];

  logic w_xfer;

  // Instruction field decode from IR
  logic [6:0] w_opcode, w_f7;
  logic [4:0] w_rd, w_rs1, w_rs2;
  logic [2:0] w_f3;
  assign w_opcode = r_ir[6:0];
  assign w_rd     = r_ir[11:7];
  assign w_f3     = r_ir[14:12];
  assign w_rs1    = r_ir[19:15];
  assign w_rs2    = r_ir[24:20];
  assign w_f7     = r_ir[31:25];

  logic w_is_add, w_is_sub, w_is_and, w_is_or, w_is_rtype;
  logic w_is_addi, w_is_lui, w_is_beq, w_is_bne, w_is_branch;
  logic w_is_load, w_is_store, w_is_ecall, w_is_legal;

  assign w_is_add    = (w_opcode == OP_R) && (w_f3 == 3'b000) && (w_f7 == 7'b0000000);
  assign w_is_sub    = (w_opcode == OP_R) && (w_f3 == 3'b000) && (w_f7 == 7'b0100000);
  assign w_is_and    = (w_opcode == OP_R) && (w_f3 == 3'b111) && (w_f7 == 7'b0000000);
  assign w_is_or     = (w_opcode == OP_R) && (w_f3 == 3'b110) && (w_f7 == 7'b0000000);
  assign w_is_rtype  = w_is_add | w_is_sub | w_is_and | w_is_or;
  assign w_is_addi   = (w_opcode == OP_I) && (w_f3 == 3'b000);
  assign w_is_lui    = (w_opcode == OP_LUI);
  assign w_is_beq    = (w_opcode == OP_BR) && (w_f3 == 3'b000);
  assign w_is_bne    = (w_opcode == OP_BR) && (w_f3 == 3'b001);
  assign w_is_branch = w_is_beq | w_is_bne;
  assign w_is_load   = (w_opcode == OP_LD) && (w_f3 == F3_LS);
  assign w_is_store  = (w_opcode == OP_ST) && (w_f3 == F3_LS);
  assign w_is_ecall  = (r_ir == ECALL_IR);
  assign w_is_legal  = w_is_rtype | w_is_addi | w_is_lui | w_is_branch |
                       w_is_load | w_is_store;

  // Sign-extended immediates
  logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u;
  assign w_imm_i = XLEN'($signed(r_ir[31:20]));
  assign w_imm_s = XLEN'($signed({r_ir[31:25], r_ir[11:7]}));
  assign w_imm_b = XLEN'($signed({r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0}));
  assign w_imm_u = XLEN'($signed({r_ir[31:12], 12'b0}));

  // Register file read ports; x0 is hard-wired to zero
  logic [XLEN-1:0] w_rs1_val, w_rs2_val;
  assign w_rs1_val = (w_rs1 == 5'd0) ? '0 : r_regs[w_rs1];
  assign w_rs2_val = (w_rs2 == 5'd0) ? '0 : r_regs[w_rs2];
  assign dbg_rdata = (dbg_rs == 5'd0) ? '0 : r_regs[dbg_rs];

  // ALU for R-type operations
  logic [XLEN-1:0] w_alu;
  always_comb begin
    w_alu = r_a + r_b;
    if (w_is_sub)      w_alu = r_a - r_b;
    else if (w_is_and) w_alu = r_a & r_b;
    else if (w_is_or)  w_alu = r_a | r_b;
  end

  // Result latched into ALUOut during EXEC
  logic [XLEN-1:0] w_exec_res;
  always_comb begin
    w_exec_res = r_a + w_imm_i;
    if (w_is_rtype)      w_exec_res = w_alu;
    else if (w_is_lui)   w_exec_res = w_imm_u;
    else if (w_is_store) w_exec_res = r_a + w_imm_s;
  end

  logic w_taken;
  assign w_taken = (w_is_beq && (r_a == r_b)) || (w_is_bne && (r_a != r_b));

  assign w_xfer = mem_req & mem_ready;

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  // FSM next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:  if (w_xfer) w_next = S_DECODE;
      S_DECODE: begin
        if (w_is_ecall)       w_next = S_HALT;
        else if (!w_is_legal) w_next = S_TRAP;
        else                  w_next = S_EXEC;
      end
      S_EXEC: begin
        if (w_is_load || w_is_store) w_next = S_MEM;
        else if (w_is_branch)        w_next = S_FETCH;
        else                         w_next = S_WB;
      end
      S_MEM:    if (w_xfer) w_next = w_is_load ? S_WB : S_FETCH;
      S_WB:     w_next = S_FETCH;
      default:  w_next = r_state;
    endcase
  end

  // FSM outputs; reset gates the request so it drops the moment reset asserts
  always_comb begin
    mem_req = 1'b0;
    mem_we  = 1'b0;
    case (r_state)
      S_FETCH: mem_req = reset;
      S_MEM: begin
        mem_req = reset;
        mem_we  = reset & w_is_store;
      end
      default: ;
    endcase
  end

  // Address and data come from registers that only move on a transfer, so they
  // stay stable across wait states
  assign mem_addr  = (r_state == S_FETCH) ? ADDR_W'(r_pc) : ADDR_W'(r_aluout);
  assign mem_wdata = r_b;

  // Datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc      <= RESET_PC;
      r_pc_old  <= RESET_PC;
      r_ir      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_aluout  <= '0;
      r_mdr     <= '0;
      r_halted  <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: if (w_xfer) begin
          r_ir     <= mem_rdata[31:0];
          r_pc_old <= r_pc;
          r_pc     <= r_pc + XLEN'(4);
        end
        S_DECODE: begin
          r_a      <= w_rs1_val;
          r_b      <= w_rs2_val;
          r_aluout <= r_pc_old + w_imm_b;
        end
        S_EXEC: begin
          if (w_is_branch) begin
            if (w_taken) r_pc <= r_aluout;
          end else begin
            r_aluout <= w_exec_res;
          end
        end
        S_MEM:  if (w_xfer && w_is_load) r_mdr <= mem_rdata;
        S_HALT: r_halted  <= 1'b1;
        S_TRAP: r_illegal <= 1'b1;
        default: ;
      endcase
    end
  end

  // Register file write-back; rd=0 is dropped
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(NREGS); i++) r_regs[i] <= '0;
    end else if ((r_state == S_WB) && (w_rd != 5'd0)) begin
      r_regs[w_rd] <= w_is_load ? r_mdr : r_aluout;
    end
  end

  assign instruction_out = r_ir;
  assign pc_out          = r_pc;
  assign halted          = r_halted;
  assign illegal         = r_illegal;

endmodule
